irq_priority_controller: RTL and testbench



---
 rtl/irq_priority_controller_if.sv | 38 +++
 rtl/irq_priority_controller.sv | 133 +++++++++++++
 tb/tb_irq_priority_controller.sv | 394 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/irq_priority_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : irq_priority_controller_if
// Brief    : Request/acknowledge/status bundle between the interrupt controller
//            and the fetch/hazard/EXM side of the pipeline.
// Revision : 1.0
// ============================================================================
interface irq_priority_controller_if #(
    parameter int N_IRQ = 4,
    parameter int PC_W  = 32
);
    localparam int c_id_w = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

    logic [N_IRQ-1:0]  i_irq;
    logic              i_mask_we;
    logic [N_IRQ-1:0]  i_mask_data;
    logic              i_stall;
    logic              i_ack;
    logic              i_reti;
    logic              o_interrupt_call;
    logic [c_id_w-1:0] o_irq_id;
    logic [PC_W-1:0]   o_vector;
    logic [N_IRQ-1:0]  o_pending;
    logic              o_in_service;

    // Controller side.
    modport slave (
        input  i_irq, i_mask_we, i_mask_data, i_stall, i_ack, i_reti,
        output o_interrupt_call, o_irq_id, o_vector, o_pending, o_in_service
    );

    // Pipeline side.
    modport master (
        output i_irq, i_mask_we, i_mask_data, i_stall, i_ack, i_reti,
        input  o_interrupt_call, o_irq_id, o_vector, o_pending, o_in_service
    );
endinterface
`default_nettype wire

// File: rtl/irq_priority_controller.sv
`default_nettype none
// ============================================================================
// Module   : irq_priority_controller
// Brief    : Multi-source fixed-priority interrupt controller issuing one
//            vectored call at a time to fetch, held until return-from-interrupt.
// Revision : 1.0
// ============================================================================
module irq_priority_controller #(
    parameter int               N_IRQ         = 4,
    parameter int               PC_W          = 32,
    parameter logic [N_IRQ-1:0] EDGE_MODE     = 4'b1111,
    parameter logic [N_IRQ-1:0] MASK_RESET    = 4'b1111,
    parameter logic [PC_W-1:0]  VECTOR_BASE   = 32'h0000_0000,
    parameter logic [PC_W-1:0]  VECTOR_STRIDE = PC_W'(2)
) (
    input  wire logic                i_clk,
    input  wire logic                i_reset,
    irq_priority_controller_if.slave bus
);
    localparam int c_id_w = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_REQUEST    = 2'd1,
        ST_IN_SERVICE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [N_IRQ-1:0]   r_prev_irq;
    logic [N_IRQ-1:0]   r_pending;
    logic [N_IRQ-1:0]   r_mask;
    logic [N_IRQ-1:0]   w_pending_nxt;
    logic [N_IRQ-1:0]   w_eligible;
    logic [c_id_w-1:0]  r_irq_id;
    logic [c_id_w-1:0]  w_sel_id;
    logic [PC_W-1:0]    r_vector;
    logic [PC_W-1:0]    w_sel_vector;
    logic               w_any_eligible;
    logic               w_take_req;
    logic               w_take_ack;
    logic               w_call;
    logic               w_in_service;

    assign w_eligible     = r_pending & r_mask;
    assign w_any_eligible = |w_eligible;
    assign w_take_req     = (r_state == ST_IDLE) && w_any_eligible && !bus.i_stall;
    assign w_take_ack     = (r_state == ST_REQUEST) && bus.i_ack;

    generate
        for (genvar c = 0; c < N_IRQ; c++) begin : g_chan
            if (EDGE_MODE[c]) begin : g_edge
                // A fresh edge in the ack cycle outranks the clear.
                assign w_pending_nxt[c] =
                    (r_pending[c] & ~(w_take_ack && (r_irq_id == c_id_w'(c))))
                    | (bus.i_irq[c] & ~r_prev_irq[c]);
            end else begin : g_level
                assign w_pending_nxt[c] = bus.i_irq[c];
            end
        end
    endgenerate

    // Lowest index wins: scan downward so the last hit is the smallest.
    always_comb begin
        w_sel_id = '0;
        for (int c = N_IRQ - 1; c >= 0; c--) begin
            if (w_eligible[c]) begin
                w_sel_id = c_id_w'(c);
            end
        end
    end

    assign w_sel_vector = VECTOR_BASE + (PC_W'(w_sel_id) * VECTOR_STRIDE);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= ST_IDLE;
            r_prev_irq <= '0;
            r_pending  <= '0;
            r_mask     <= MASK_RESET;
            r_irq_id   <= '0;
            r_vector   <= VECTOR_BASE;
        end else begin
            r_state    <= w_state_nxt;
            r_prev_irq <= bus.i_irq;
            r_pending  <= w_pending_nxt;
            if (bus.i_mask_we) begin
                r_mask <= bus.i_mask_data;
            end
            // Id and vector freeze once a request is issued.
            if (w_take_req) begin
                r_irq_id <= w_sel_id;
                r_vector <= w_sel_vector;
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_call       = 1'b0;
        w_in_service = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_take_req) begin
                    w_state_nxt = ST_REQUEST;
                end
            end
            ST_REQUEST: begin
                w_call = ~bus.i_stall;
                if (bus.i_ack) begin
                    w_state_nxt = ST_IN_SERVICE;
                end
            end
            ST_IN_SERVICE: begin
                w_in_service = 1'b1;
                if (bus.i_reti) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus.o_interrupt_call = w_call;
    assign bus.o_in_service     = w_in_service;
    assign bus.o_irq_id         = r_irq_id;
    assign bus.o_vector         = r_vector;
    assign bus.o_pending        = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_irq_priority_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_irq_priority_controller
// Brief    : Self-checking bench for irq_priority_controller (edge and mixed
//            edge/level instances) with an expected-call scoreboard queue.
// Revision : 1.0
// ============================================================================
module tb_irq_priority_controller;
    localparam int              N_IRQ      = 4;
    localparam int              PC_W       = 32;
    localparam int              ID_W       = 2;
    localparam logic [PC_W-1:0] VEC_BASE   = 32'h0000_0000;
    localparam logic [PC_W-1:0] VEC_STRIDE = 32'd2;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [PC_W-1:0] vec;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    irq_priority_controller_if #(.N_IRQ(N_IRQ), .PC_W(PC_W)) bus_a ();
    irq_priority_controller_if #(.N_IRQ(N_IRQ), .PC_W(PC_W)) bus_b ();

    irq_priority_controller #(
        .N_IRQ(N_IRQ), .PC_W(PC_W), .EDGE_MODE(4'b1111), .MASK_RESET(4'b1111),
        .VECTOR_BASE(VEC_BASE), .VECTOR_STRIDE(VEC_STRIDE)
    ) dut_a (
        .i_clk(clk), .i_reset(rst), .bus(bus_a)
    );

    irq_priority_controller #(
        .N_IRQ(N_IRQ), .PC_W(PC_W), .EDGE_MODE(4'b1110), .MASK_RESET(4'b1111),
        .VECTOR_BASE(VEC_BASE), .VECTOR_STRIDE(VEC_STRIDE)
    ) dut_b (
        .i_clk(clk), .i_reset(rst), .bus(bus_b)
    );

    function automatic exp_t model_call(input int id);
        exp_t e;
        e.id  = ID_W'(id);
        e.vec = VEC_BASE + (PC_W'(id) * VEC_STRIDE);
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus_a.i_irq = '0; bus_a.i_mask_we = 1'b0; bus_a.i_mask_data = '0;
        bus_a.i_stall = 1'b0; bus_a.i_ack = 1'b0; bus_a.i_reti = 1'b0;
        bus_b.i_irq = '0; bus_b.i_mask_we = 1'b0; bus_b.i_mask_data = '0;
        bus_b.i_stall = 1'b0; bus_b.i_ack = 1'b0; bus_b.i_reti = 1'b0;
    endtask

    task automatic pulse_irq(input bit use_b, input logic [N_IRQ-1:0] m);
        if (use_b) bus_b.i_irq = m; else bus_a.i_irq = m;
        tick();
        if (use_b) bus_b.i_irq = '0; else bus_a.i_irq = '0;
    endtask

    // Cycles until the call shows up, or -1 once the budget runs out.
    task automatic wait_call(input bit use_b, input int budget, output int cycles);
        int i;
        i = 0;
        cycles = -1;
        while (cycles < 0 && i < budget) begin
            i++;
            tick();
            if ((use_b ? bus_b.o_interrupt_call : bus_a.o_interrupt_call) === 1'b1)
                cycles = i;
        end
    endtask

    task automatic ack_a();
        bus_a.i_ack = 1'b1; tick(); bus_a.i_ack = 1'b0;
    endtask

    task automatic reti_a();
        bus_a.i_reti = 1'b1; tick(); bus_a.i_reti = 1'b0;
    endtask

    task automatic test_reset();
        drive_idle();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        n_vec++;
        if ({bus_a.o_interrupt_call, bus_a.o_irq_id, bus_a.o_vector, bus_a.o_pending,
             bus_a.o_in_service} !== {1'b0, 2'd0, VEC_BASE, 4'b0000, 1'b0}) begin
            n_err++;
            $display("FAIL reset_a: got call=%b id=%0d vec=%h pend=%b insvc=%b, want all 0",
                     bus_a.o_interrupt_call, bus_a.o_irq_id, bus_a.o_vector,
                     bus_a.o_pending, bus_a.o_in_service);
        end
        n_vec++;
        if ({bus_b.o_interrupt_call, bus_b.o_pending, bus_b.o_in_service} !== 6'd0) begin
            n_err++;
            $display("FAIL reset_b: got call=%b pend=%b insvc=%b, want 0",
                     bus_b.o_interrupt_call, bus_b.o_pending, bus_b.o_in_service);
        end
    endtask

    task automatic test_single_edge();
        int   cyc;
        exp_t e, got;
        pulse_irq(1'b0, 4'b0100);
        n_vec++;
        if ({bus_a.o_pending, bus_a.o_interrupt_call} !== {4'b0100, 1'b0}) begin
            n_err++;
            $display("FAIL single_pending: got pend=%b call=%b, want 0100/0",
                     bus_a.o_pending, bus_a.o_interrupt_call);
        end
        exp_q.push_back(model_call(2));
        wait_call(1'b0, 8, cyc);
        n_vec++;
        if (cyc != 1) begin
            n_err++;
            $display("FAIL single_latency: got %0d cycles, want 1", cyc);
        end
        e = exp_q.pop_front();
        got = {bus_a.o_irq_id, bus_a.o_vector};
        n_vec++;
        if (got !== e) begin
            n_err++;
            $display("FAIL single_call: got id=%0d vec=%h, want id=%0d vec=%h",
                     got.id, got.vec, e.id, e.vec);
        end
        ack_a();
        n_vec++;
        if ({bus_a.o_pending, bus_a.o_in_service, bus_a.o_interrupt_call} !== {4'b0000, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL single_ack: got pend=%b insvc=%b call=%b, want 0000/1/0",
                     bus_a.o_pending, bus_a.o_in_service, bus_a.o_interrupt_call);
        end
        reti_a();
        n_vec++;
        if ({bus_a.o_in_service, bus_a.o_interrupt_call} !== 2'b00) begin
            n_err++;
            $display("FAIL single_reti: got insvc=%b call=%b, want 0/0",
                     bus_a.o_in_service, bus_a.o_interrupt_call);
        end
    endtask

    task automatic test_priority();
        int   cyc;
        exp_t e, got;
        pulse_irq(1'b0, 4'b1010);
        exp_q.push_back(model_call(1));
        exp_q.push_back(model_call(3));
        wait_call(1'b0, 8, cyc);
        e = exp_q.pop_front();
        got = {bus_a.o_irq_id, bus_a.o_vector};
        n_vec++;
        if (cyc != 1 || got !== e) begin
            n_err++;
            $display("FAIL prio_first: got cyc=%0d id=%0d vec=%h, want cyc=1 id=%0d vec=%h",
                     cyc, got.id, got.vec, e.id, e.vec);
        end
        ack_a();
        n_vec++;
        if ({bus_a.o_pending, bus_a.o_in_service} !== {4'b1000, 1'b1}) begin
            n_err++;
            $display("FAIL prio_ack: got pend=%b insvc=%b, want 1000/1",
                     bus_a.o_pending, bus_a.o_in_service);
        end
        reti_a();
        n_vec++;
        if ({bus_a.o_interrupt_call, bus_a.o_in_service} !== 2'b00) begin
            n_err++;
            $display("FAIL prio_bubble: got call=%b insvc=%b, want 0/0",
                     bus_a.o_interrupt_call, bus_a.o_in_service);
        end
        wait_call(1'b0, 8, cyc);
        e = exp_q.pop_front();
        got = {bus_a.o_irq_id, bus_a.o_vector};
        n_vec++;
        if (cyc != 1 || got !== e) begin
            n_err++;
            $display("FAIL prio_second: got cyc=%0d id=%0d vec=%h, want cyc=1 id=%0d vec=%h",
                     cyc, got.id, got.vec, e.id, e.vec);
        end
        ack_a();
        reti_a();
    endtask

    task automatic test_stall();
        int   cyc;
        exp_t e, got;
        pulse_irq(1'b0, 4'b0001);
        exp_q.push_back(model_call(0));
        wait_call(1'b0, 8, cyc);
        e = exp_q.pop_front();
        got = {bus_a.o_irq_id, bus_a.o_vector};
        n_vec++;
        if (cyc != 1 || got !== e) begin
            n_err++;
            $display("FAIL stall_call: got cyc=%0d id=%0d, want cyc=1 id=%0d", cyc, got.id, e.id);
        end
        bus_a.i_stall = 1'b1;
        #1;
        n_vec++;
        if (bus_a.o_interrupt_call !== 1'b0) begin
            n_err++;
            $display("FAIL stall_gate: got call=%b, want 0", bus_a.o_interrupt_call);
        end
        pulse_irq(1'b0, 4'b0001);
        tick();
        n_vec++;
        if ({bus_a.o_interrupt_call, bus_a.o_irq_id, bus_a.o_in_service} !== {1'b0, 2'd0, 1'b0}) begin
            n_err++;
            $display("FAIL stall_hold: got call=%b id=%0d insvc=%b, want 0/0/0",
                     bus_a.o_interrupt_call, bus_a.o_irq_id, bus_a.o_in_service);
        end
        bus_a.i_stall = 1'b0;
        #1;
        n_vec++;
        if ({bus_a.o_interrupt_call, bus_a.o_irq_id} !== {1'b1, 2'd0}) begin
            n_err++;
            $display("FAIL stall_release: got call=%b id=%0d, want 1/0",
                     bus_a.o_interrupt_call, bus_a.o_irq_id);
        end
        ack_a();
        n_vec++;
        if (bus_a.o_pending !== 4'b0000) begin
            n_err++;
            $display("FAIL stall_ack_clear: got pend=%b, want 0000", bus_a.o_pending);
        end
        reti_a();
    endtask

    task automatic test_mask();
        int   cyc;
        exp_t e, got;
        bus_a.i_mask_we = 1'b1; bus_a.i_mask_data = 4'b1110;
        tick();
        bus_a.i_mask_we = 1'b0;
        pulse_irq(1'b0, 4'b0001);
        tick(); tick();
        n_vec++;
        if ({bus_a.o_pending, bus_a.o_interrupt_call, bus_a.o_in_service} !== {4'b0001, 2'b00}) begin
            n_err++;
            $display("FAIL mask_block: got pend=%b call=%b insvc=%b, want 0001/0/0",
                     bus_a.o_pending, bus_a.o_interrupt_call, bus_a.o_in_service);
        end
        exp_q.push_back(model_call(0));
        bus_a.i_mask_we = 1'b1; bus_a.i_mask_data = 4'b1111;
        wait_call(1'b0, 8, cyc);
        bus_a.i_mask_we = 1'b0;
        e = exp_q.pop_front();
        got = {bus_a.o_irq_id, bus_a.o_vector};
        n_vec++;
        if (cyc != 2 || got !== e) begin
            n_err++;
            $display("FAIL mask_unblock: got cyc=%0d id=%0d vec=%h, want cyc=2 id=%0d vec=%h",
                     cyc, got.id, got.vec, e.id, e.vec);
        end
        ack_a();
        reti_a();
    endtask

    task automatic test_level();
        int   cyc;
        bit   seen;
        exp_t e, got;
        bus_b.i_irq = 4'b0001;
        exp_q.push_back(model_call(0));
        wait_call(1'b1, 8, cyc);
        e = exp_q.pop_front();
        got = {bus_b.o_irq_id, bus_b.o_vector};
        n_vec++;
        if (cyc != 2 || got !== e) begin
            n_err++;
            $display("FAIL level_call: got cyc=%0d id=%0d, want cyc=2 id=%0d", cyc, got.id, e.id);
        end
        bus_b.i_ack = 1'b1; tick(); bus_b.i_ack = 1'b0;
        n_vec++;
        if ({bus_b.o_pending, bus_b.o_in_service} !== {4'b0001, 1'b1}) begin
            n_err++;
            $display("FAIL level_ack_keeps: got pend=%b insvc=%b, want 0001/1",
                     bus_b.o_pending, bus_b.o_in_service);
        end
        bus_b.i_reti = 1'b1; tick(); bus_b.i_reti = 1'b0;
        exp_q.push_back(model_call(0));
        wait_call(1'b1, 8, cyc);
        e = exp_q.pop_front();
        got = {bus_b.o_irq_id, bus_b.o_vector};
        n_vec++;
        if (cyc != 1 || got !== e) begin
            n_err++;
            $display("FAIL level_refire: got cyc=%0d id=%0d, want cyc=1 id=%0d", cyc, got.id, e.id);
        end
        bus_b.i_ack = 1'b1; tick(); bus_b.i_ack = 1'b0;
        bus_b.i_irq = 4'b0000;
        tick();
        bus_b.i_reti = 1'b1; tick(); bus_b.i_reti = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus_b.o_interrupt_call !== 1'b0) seen = 1'b1;
        end
        n_vec++;
        if (seen || bus_b.o_pending !== 4'b0000) begin
            n_err++;
            $display("FAIL level_dropped: got call_seen=%b pend=%b, want 0/0000",
                     seen, bus_b.o_pending);
        end
    endtask

    task automatic test_back_to_back();
        int   cyc;
        bit   seen;
        exp_t e, got;
        pulse_irq(1'b0, 4'b0100);
        exp_q.push_back(model_call(2));
        wait_call(1'b0, 8, cyc);
        e = exp_q.pop_front();
        got = {bus_a.o_irq_id, bus_a.o_vector};
        n_vec++;
        if (cyc != 1 || got !== e) begin
            n_err++;
            $display("FAIL b2b_call: got cyc=%0d id=%0d, want cyc=1 id=%0d", cyc, got.id, e.id);
        end
        bus_a.i_ack = 1'b1; bus_a.i_reti = 1'b1;
        tick();
        bus_a.i_ack = 1'b0; bus_a.i_reti = 1'b0;
        n_vec++;
        if ({bus_a.o_in_service, bus_a.o_interrupt_call} !== 2'b10) begin
            n_err++;
            $display("FAIL b2b_ack_reti: got insvc=%b call=%b, want 1/0",
                     bus_a.o_in_service, bus_a.o_interrupt_call);
        end
        pulse_irq(1'b0, 4'b0010);
        ack_a();
        n_vec++;
        if ({bus_a.o_in_service, bus_a.o_irq_id, bus_a.o_pending} !== {1'b1, 2'd2, 4'b0010}) begin
            n_err++;
            $display("FAIL b2b_ack_ignored: got insvc=%b id=%0d pend=%b, want 1/2/0010",
                     bus_a.o_in_service, bus_a.o_irq_id, bus_a.o_pending);
        end
        rst = 1'b1; tick(); rst = 1'b0;
        n_vec++;
        if ({bus_a.o_interrupt_call, bus_a.o_irq_id, bus_a.o_vector, bus_a.o_pending,
             bus_a.o_in_service} !== {1'b0, 2'd0, VEC_BASE, 4'b0000, 1'b0}) begin
            n_err++;
            $display("FAIL midservice_reset: got call=%b id=%0d vec=%h pend=%b insvc=%b, want all 0",
                     bus_a.o_interrupt_call, bus_a.o_irq_id, bus_a.o_vector,
                     bus_a.o_pending, bus_a.o_in_service);
        end
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus_a.o_interrupt_call !== 1'b0) seen = 1'b1;
        end
        n_vec++;
        if (seen) begin
            n_err++;
            $display("FAIL reset_lost_pending: got call after reset, want none");
        end
    endtask

    initial begin
        test_reset();
        test_single_edge();
        test_priority();
        test_stall();
        test_mask();
        test_level();
        test_back_to_back();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
